// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        FIXUP,
        DONE
    } div_state_t;

    // Sliced down to DATA_WIDTH by the divider; wide enough for any practical width.
    localparam logic [63:0] DIV_ZERO_QUOTIENT = '1;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division stage: shift in a dividend bit, trial-subtract.
module div_step #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] rem,
    input  logic          dbit,
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] next_rem,
    output logic          qbit
);

    logic [DW:0]   partial;
    logic [DW-1:0] diff;

    // The running remainder is always below the divisor, so the kept difference fits DW bits.
    always_comb begin
        partial  = {rem, dbit};
        qbit     = (partial >= {1'b0, divisor});
        diff     = partial[DW-1:0] - divisor;
        next_rem = qbit ? diff : partial[DW-1:0];
    end

endmodule

// File: rtl/divide.sv
// Multi-cycle restoring divider, 2*DATA_WIDTH / DATA_WIDTH, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands (adds a FIXUP cycle).
module divide
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [2*DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0]   divisor,
    output logic [DATA_WIDTH-1:0]   quotient,
    output logic [DATA_WIDTH-1:0]   remainder,
    output logic                    div_zero,
    output logic                    overflow,
    output logic                    busy,
    output logic                    complete
);

    localparam int DW = DATA_WIDTH;
    localparam int CW = cnt_width(DW);

    div_state_t    state, state_next;
    logic [CW-1:0] count;
    logic [DW-1:0] rem_r;
    logic [DW-1:0] shift_r;      // low dividend bits shift out, quotient bits shift in
    logic [DW-1:0] divisor_r;

    logic [2*DW-1:0] dvd_mag;
    logic [DW-1:0]   dvs_mag;
    logic            is_zero;
    logic            is_ovf;
    logic [DW-1:0]   step_rem;
    logic            step_q;

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;
`endif

    always_comb begin
`ifdef DIV_SIGNED_EN
        dvd_mag = dividend[2*DW-1] ? -dividend : dividend;
        dvs_mag = divisor[DW-1] ? -divisor : divisor;
`else
        dvd_mag = dividend;
        dvs_mag = divisor;
`endif
        is_zero = (divisor == '0);
        // Upper half not below the divisor means the quotient needs more than DW bits.
        is_ovf  = (dvd_mag[2*DW-1:DW] >= dvs_mag);
    end

    div_step #(.DW(DW)) u_step (
        .rem     (rem_r),
        .dbit    (shift_r[DW-1]),
        .divisor (divisor_r),
        .next_rem(step_rem),
        .qbit    (step_q)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = (is_zero || is_ovf) ? DONE : DIVIDE;
            end
            DIVIDE: begin
                if (count == '0) begin
`ifdef DIV_SIGNED_EN
                    state_next = FIXUP;
`else
                    state_next = DONE;
`endif
                end
            end
            FIXUP:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        busy     = (state != IDLE);
        complete = (state == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    // NOTE: working registers are reset too, keeping the design free of X after an aborted operation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count     <= '0;
            rem_r     <= '0;
            shift_r   <= '0;
            divisor_r <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count     <= CW'(DW - 1);
                        rem_r     <= dvd_mag[2*DW-1:DW];
                        shift_r   <= dvd_mag[DW-1:0];
                        divisor_r <= dvs_mag;
                        div_zero  <= 1'b0;
                        overflow  <= 1'b0;
`ifdef DIV_SIGNED_EN
                        neg_q     <= dividend[2*DW-1] ^ divisor[DW-1];
                        neg_r     <= dividend[2*DW-1];
`endif
                        if (is_zero) begin
                            div_zero  <= 1'b1;
                            quotient  <= DIV_ZERO_QUOTIENT[DW-1:0];
                            remainder <= dividend[DW-1:0];
                        end else if (is_ovf) begin
                            overflow  <= 1'b1;
                            quotient  <= '0;
                            remainder <= '0;
                        end
                    end
                end
                DIVIDE: begin
                    rem_r   <= step_rem;
                    shift_r <= {shift_r[DW-2:0], step_q};
                    count   <= count - 1'b1;
`ifndef DIV_SIGNED_EN
                    if (count == '0) begin
                        quotient  <= {shift_r[DW-2:0], step_q};
                        remainder <= step_rem;
                    end
`endif
                end
`ifdef DIV_SIGNED_EN
                FIXUP: begin
                    // A magnitude quotient of 2**(DW-1) or more is treated as unrepresentable.
                    if (shift_r[DW-1]) begin
                        overflow  <= 1'b1;
                        quotient  <= '0;
                        remainder <= '0;
                    end else begin
                        quotient  <= neg_q ? -shift_r : shift_r;
                        remainder <= neg_r ? -rem_r : rem_r;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
